// File: rtl/plab4_net_tdm_domain_sched.sv
// rtl/plab4_net_tdm_domain_sched.sv - time-division domain scheduler for one router output port
//
// Alternates ownership of the output port between security domains 0 and 1
// in fixed-length ACT slots, each followed by a DEAD_CYCLES drain gap, and
// round-robins among the requesters of the owning domain only. The slot
// schedule is purely time-driven, so grant timing in one domain is
// independent of the other domain's traffic.
//
// Optional feature macro: PLAB4_NET_TDM_GRANT_CNT_EN (adds per-domain
// saturating grant counters grant_cnt0/grant_cnt1).
//
// Ports:
//   clk         clock, all state on posedge
//   reset       asynchronous active-low reset
//   reqs        per-port request for this output
//   req_dom     per-port domain tag of the head flit
//   grants      one-hot grant, or all zero
//   out_val     output flit valid (= |grants)
//   out_rdy     downstream ready
//   xbar_sel    cur_dom*NPORTS + granted port, 0 when idle
//   cur_dom     domain owning the current slot
//   grant_cnt0  domain-0 grant count (macro only)
//   grant_cnt1  domain-1 grant count (macro only)

module plab4_net_tdm_domain_sched #(
  parameter int NPORTS      = 3,
  parameter int SLOT_CYCLES = 8,
  parameter int DEAD_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NPORTS-1:0]                 reqs,
  input  logic [NPORTS-1:0]                 req_dom,
  output logic [NPORTS-1:0]                 grants,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [$clog2(2*NPORTS)-1:0]       xbar_sel,
  output logic                              cur_dom
`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
  ,
  output logic [15:0]                       grant_cnt0,
  output logic [15:0]                       grant_cnt1
`endif
);

  localparam int SW = $clog2(2*NPORTS);
  localparam int PW = $clog2(NPORTS);
  localparam int CW = $clog2(SLOT_CYCLES + DEAD_CYCLES + 1);

  typedef enum logic [1:0] {
    D0_ACT = 2'b00,
    D0_DRN = 2'b01,
    D1_ACT = 2'b10,
    D1_DRN = 2'b11
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [PW-1:0]   ptr0;
  logic [PW-1:0]   ptr1;
  logic [PW-1:0]   ptr_cur;
  logic [PW-1:0]   gnt_idx;
  logic            found;
  logic            active;
  logic [NPORTS-1:0] eligible;
  int              rr_idx;

  // State and slot counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= D0_ACT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Time-driven schedule; the counter restarts on every state change
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    case (state)
      D0_ACT: if (cnt == CW'(SLOT_CYCLES - 1)) begin
        state_next = (DEAD_CYCLES == 0) ? D1_ACT : D0_DRN;
        cnt_next   = '0;
      end
      D0_DRN: if (cnt == CW'(DEAD_CYCLES - 1)) begin
        state_next = D1_ACT;
        cnt_next   = '0;
      end
      D1_ACT: if (cnt == CW'(SLOT_CYCLES - 1)) begin
        state_next = (DEAD_CYCLES == 0) ? D0_ACT : D1_DRN;
        cnt_next   = '0;
      end
      D1_DRN: if (cnt == CW'(DEAD_CYCLES - 1)) begin
        state_next = D0_ACT;
        cnt_next   = '0;
      end
      default: begin
        state_next = D0_ACT;
        cnt_next   = '0;
      end
    endcase
  end

  assign cur_dom = (state == D1_ACT) || (state == D1_DRN);

  // Reset gates grants directly so an asserted reset silences the port at once
  assign active   = reset && out_rdy && ((state == D0_ACT) || (state == D1_ACT));
  assign eligible = reqs & ~(req_dom ^ {NPORTS{cur_dom}});
  assign ptr_cur  = cur_dom ? ptr1 : ptr0;

  // Round-robin: first eligible port at or after the current domain's pointer
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (active) begin
      for (int off = 0; off < NPORTS; off++) begin
        rr_idx = int'(ptr_cur) + off;
        if (rr_idx >= NPORTS) rr_idx = rr_idx - NPORTS;
        if (!found && eligible[rr_idx]) begin
          found   = 1'b1;
          gnt_idx = PW'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    grants   = '0;
    xbar_sel = '0;
    if (found) begin
      grants[gnt_idx] = 1'b1;
      xbar_sel        = (cur_dom ? SW'(NPORTS) : SW'(0)) + SW'(gnt_idx);
    end
  end

  assign out_val = found;

  // Only the owning domain's pointer advances
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr0 <= '0;
      ptr1 <= '0;
    end else if (found) begin
      if (gnt_idx == PW'(NPORTS - 1)) begin
        if (cur_dom) ptr1 <= '0;
        else         ptr0 <= '0;
      end else begin
        if (cur_dom) ptr1 <= gnt_idx + PW'(1);
        else         ptr0 <= gnt_idx + PW'(1);
      end
    end
  end

`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (found) begin
      if (!cur_dom && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if ( cur_dom && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plab4_net_tdm_domain_sched.sv
// tb/tb_plab4_net_tdm_domain_sched.sv - self-checking bench for plab4_net_tdm_domain_sched
module tb_plab4_net_tdm_domain_sched;

  localparam int N = 3;
  localparam int S = 4;
  localparam int D = 1;
  localparam int P = 2 * (S + D);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] reqs = '0;
  logic [2:0] req_dom = '0;
  logic       out_rdy = 1'b0;
  logic [2:0] grants;
  logic       out_val;
  logic [2:0] xbar_sel;
  logic       cur_dom;
`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  plab4_net_tdm_domain_sched #(.NPORTS(N), .SLOT_CYCLES(S), .DEAD_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .reqs(reqs), .req_dom(req_dom),
    .grants(grants), .out_val(out_val), .out_rdy(out_rdy),
    .xbar_sel(xbar_sel), .cur_dom(cur_dom)
`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle number since reset plus per-domain pointers/counters
  int t;
  int mptr [2];
  int mcnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_clear();
    t = 0;
    mptr[0] = 0; mptr[1] = 0;
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_grants", 32'(grants), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_cur_dom", 32'(cur_dom), 32'd0);
    check("rst_xbar_sel", 32'(xbar_sel), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    model_clear();
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] d, input logic rdy,
                      output logic [2:0] g_obs);
    int ph, dom, k, p;
    logic act;
    @(negedge clk);
    reqs = r; req_dom = d; out_rdy = rdy;
    #1;
    ph  = t % P;
    dom = (ph >= S + D) ? 1 : 0;
    act = (ph % (S + D)) < S;
    k   = -1;
    if (act && rdy) begin
      for (int off = 0; off < N; off++) begin
        p = (mptr[dom] + off) % N;
        if (k < 0 && r[p] && (d[p] == dom[0])) k = p;
      end
    end
    check("grants", 32'(grants), (k >= 0) ? (32'd1 << k) : 32'd0);
    check("out_val", 32'(out_val), (k >= 0) ? 32'd1 : 32'd0);
    check("xbar_sel", 32'(xbar_sel), (k >= 0) ? 32'(dom * N + k) : 32'd0);
    check("cur_dom", 32'(cur_dom), 32'(dom));
`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
    check("grant_cnt0", 32'(grant_cnt0), 32'(mcnt[0]));
    check("grant_cnt1", 32'(grant_cnt1), 32'(mcnt[1]));
`endif
    g_obs = grants;
    if (k >= 0) begin
      mptr[dom] = (k + 1) % N;
      if (mcnt[dom] < 65535) mcnt[dom]++;
    end
    t++;
  endtask

  logic [2:0] exp3 [11] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
  logic [2:0] pat_r [2*P];
  logic       pat_k [2*P];
  logic [2:0] g_a   [2*P];
  logic [2:0] g_b   [2*P];

  initial begin
    logic [2:0] g;
    model_clear();

    // 1: reset with idle inputs
    do_reset();
    step(3'b000, 3'b000, 1'b1, g);

    // 2: out_rdy gating, then grant to port 2
    do_reset();
    step(3'b100, 3'b000, 1'b0, g);
    check("t2_rdy_low", 32'(g), 32'd0);
    step(3'b100, 3'b000, 1'b1, g);
    check("t2_grant", 32'(g), 32'b100);
    check("t2_xbar", 32'(xbar_sel), 32'd2);

    // 3: all domain-0 requesters, full period plus resume
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(3'b111, 3'b000, 1'b1, g);
      check("t3_seq", 32'(g), 32'(exp3[i]));
`ifdef PLAB4_NET_TDM_GRANT_CNT_EN
      if (i == 4) begin
        check("t3_cnt0", 32'(grant_cnt0), 32'd4);
        check("t3_cnt1", 32'(grant_cnt1), 32'd0);
      end
`endif
    end

    // 4: mixed domains
    do_reset();
    for (int i = 0; i < 2 * P; i++) step(3'b011, 3'b010, 1'b1, g);

    // 6: reset in the third D1_ACT cycle with domain-1 traffic present
    do_reset();
    for (int i = 0; i < S + D + 2; i++) step(3'b111, 3'b111, 1'b1, g);
    check("t6_pre_grant", 32'(grants != 3'b000), 32'd1);
    do_reset();

    // 5: domain-1 grants unaffected by domain-0 traffic
    for (int i = 0; i < 2 * P; i++) begin
      pat_r[i] = 3'($urandom_range(0, 3)) << 1;
      pat_k[i] = 1'($urandom_range(0, 3) != 0);
    end
    do_reset();
    for (int i = 0; i < 2 * P; i++) step(pat_r[i], 3'b110, pat_k[i], g_a[i]);
    do_reset();
    for (int i = 0; i < 2 * P; i++) step(pat_r[i] | 3'b001, 3'b110, pat_k[i], g_b[i]);
    for (int i = 0; i < 2 * P; i++)
      check("t5_nonint", 32'(g_b[i][2:1]), 32'(g_a[i][2:1]));

    // Randomized traffic with occasional mid-slot resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      step(3'($urandom), 3'($urandom), 1'($urandom_range(0, 4) != 0), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
